// File: rtl/mips_reg_write_arbiter.sv
// mips_reg_write_arbiter
//
// Shares the single register-file write port among NREQ writeback sources
// (ALU writeback, load writeback, mult/div result, ...). A requester may hold
// the port across several beats with req_lock so a multi-beat write is never
// interleaved with another source. Accepted beats pass through one register
// stage before they reach the register file.
//
// Optional build macro:
//   MIPS_WRARB_FIXED_PRIO_EN - ARB state uses fixed priority (lowest index
//                              wins) and the round-robin pointer is removed.
//                              Without it, ARB scans round-robin from rr_ptr.
//
// Parameters:
//   NREQ      number of requesters (2..8)
//   MAX_LOCK  idle cycles tolerated in LOCKED before the lock is dropped (1..255)
//
// Ports:
//   CLK           clock, rising edge
//   rst           asynchronous reset, active low
//   hold          pipeline hold, blocks every grant while 1
//   req_valid     per-requester write pending
//   req_lock      per-requester "keep the port after this beat"
//   req_addr      5-bit destination register per requester (bits 5i+4:5i)
//   req_data      32-bit write data per requester (bits 32i+31:32i)
//   req_ready     one-hot combinational grant
//   RegWrite      register-file write enable (one cycle after acceptance)
//   WriteAddress  register-file write address
//   DataIn        register-file write data
//   locked        1 while the arbiter is held by a locking requester

module mips_reg_write_arbiter #(
    parameter int NREQ     = 3,
    parameter int MAX_LOCK = 8
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [5*NREQ-1:0]    req_addr,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 RegWrite,
    output logic [4:0]           WriteAddress,
    output logic [31:0]          DataIn,
    output logic                 locked
);

    localparam int              IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);
    // Value of lock_cnt whose increment would reach MAX_LOCK.
    localparam logic [7:0]      LOCK_LIMIT = 8'(MAX_LOCK - 1);

    typedef enum logic {
        ARB,
        LOCKED
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IDXW-1:0] owner;
    logic [IDXW-1:0] owner_next;
    logic [7:0]      lock_cnt;
    logic [7:0]      lock_cnt_next;
`ifndef MIPS_WRARB_FIXED_PRIO_EN
    logic [IDXW-1:0] rr_ptr;
    logic [IDXW-1:0] rr_ptr_next;
`endif

    logic            grant_any;
    logic [IDXW-1:0] grant_idx;
    logic            sel_lock;
    logic [4:0]      sel_addr;
    logic [31:0]     sel_data;

    function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    // State register.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state    <= ARB;
            owner    <= '0;
            lock_cnt <= '0;
`ifndef MIPS_WRARB_FIXED_PRIO_EN
            rr_ptr   <= '0;
`endif
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            lock_cnt <= lock_cnt_next;
`ifndef MIPS_WRARB_FIXED_PRIO_EN
            rr_ptr   <= rr_ptr_next;
`endif
        end
    end

    // Output logic: grant selection and status. Gating with rst keeps
    // req_ready low for the whole reset window, so no beat can be taken then.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        locked    = (state == LOCKED);
        if (rst && !hold) begin
            if (state == LOCKED) begin
                if (req_valid[owner]) begin
                    grant_any = 1'b1;
                    grant_idx = owner;
                end
            end else begin
`ifdef MIPS_WRARB_FIXED_PRIO_EN
                // Descending scan so the lowest valid index is kept last.
                for (int i = NREQ - 1; i >= 0; i--) begin
                    if (req_valid[i]) begin
                        grant_any = 1'b1;
                        grant_idx = IDXW'(i);
                    end
                end
`else
                // Descending offset scan so the requester closest to rr_ptr wins.
                for (int k = NREQ - 1; k >= 0; k--) begin
                    idx = int'(rr_ptr) + k;
                    if (idx >= NREQ) begin
                        idx = idx - NREQ;
                    end
                    if (req_valid[idx]) begin
                        grant_any = 1'b1;
                        grant_idx = IDXW'(idx);
                    end
                end
`endif
            end
            if (grant_any) begin
                req_ready[grant_idx] = 1'b1;
            end
        end
    end

    // Mux the granted requester's lock flag, address and data.
    always_comb begin
        sel_lock = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDXW'(i)) begin
                sel_lock = req_lock[i];
                sel_addr = req_addr[i*5 +: 5];
                sel_data = req_data[i*32 +: 32];
            end
        end
    end

    // Next-state logic. In LOCKED an idle cycle whose count would reach
    // MAX_LOCK releases the lock; that cycle has no grant by definition.
    always_comb begin
        state_next    = state;
        owner_next    = owner;
        lock_cnt_next = lock_cnt;
`ifndef MIPS_WRARB_FIXED_PRIO_EN
        rr_ptr_next   = rr_ptr;
`endif
        case (state)
            ARB: begin
                if (grant_any) begin
                    if (sel_lock) begin
                        owner_next    = grant_idx;
                        lock_cnt_next = '0;
                        state_next    = LOCKED;
                    end else begin
`ifndef MIPS_WRARB_FIXED_PRIO_EN
                        rr_ptr_next = wrap_inc(grant_idx);
`endif
                    end
                end
            end
            LOCKED: begin
                if (grant_any) begin
                    if (sel_lock) begin
                        lock_cnt_next = '0;
                    end else begin
                        state_next    = ARB;
                        lock_cnt_next = '0;
`ifndef MIPS_WRARB_FIXED_PRIO_EN
                        rr_ptr_next   = wrap_inc(owner);
`endif
                    end
                end else if (lock_cnt >= LOCK_LIMIT) begin
                    state_next    = ARB;
                    lock_cnt_next = '0;
`ifndef MIPS_WRARB_FIXED_PRIO_EN
                    rr_ptr_next   = wrap_inc(owner);
`endif
                end else begin
                    lock_cnt_next = lock_cnt + 8'd1;
                end
            end
            default: begin
                state_next = ARB;
            end
        endcase
    end

    // Writeback register stage. Register 0 is hardwired, so a beat aimed at
    // it is consumed but never enables the write.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            RegWrite     <= 1'b0;
            WriteAddress <= '0;
            DataIn       <= '0;
        end else if (grant_any) begin
            RegWrite     <= (sel_addr != 5'd0);
            WriteAddress <= sel_addr;
            DataIn       <= sel_data;
        end else begin
            RegWrite     <= 1'b0;
        end
    end

endmodule
